// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS controller: Moore FSM that sequences a unified-memory
// datapath through fetch/decode/execute/memory/writeback. It stalls on the
// memory request/ack handshake and counts retired instructions.
module mips_multicycle_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ack,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_REX     = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_ILLEGAL = 4'd9
    } st_t;

    st_t        st;
    logic [5:0] op_q;
    logic       illegal_q;

    // State sequencing, opcode capture, sticky illegal flag and retire counter.
    // Everything after DECODE steers on op_q so a changing IR cannot upset
    // an instruction already in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= S_FETCH;
            op_q        <= 6'h00;
            instr_count <= '0;
            illegal_q   <= 1'b0;
        end else begin
            case (st)
                S_FETCH:  if (mem_ack) st <= S_DECODE;
                S_DECODE: begin
                    op_q <= opcode;
                    if (opcode == OP_LW || opcode == OP_SW) st <= S_MEMADR;
                    else if (opcode == OP_RTYPE)            st <= S_REX;
                    else if (opcode == OP_BEQ)              st <= S_BRANCH;
                    else begin
                        st        <= S_ILLEGAL;
                        illegal_q <= 1'b1;
                    end
                end
                S_MEMADR: st <= (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (mem_ack) st <= S_MEMWB;
                S_MEMWB: begin
                    st          <= S_FETCH;
                    instr_count <= instr_count + CNT_W'(1);
                end
                S_MEMWR: if (mem_ack) begin
                    st          <= S_FETCH;
                    instr_count <= instr_count + CNT_W'(1);
                end
                S_REX:    st <= S_RWB;
                S_RWB, S_BRANCH: begin
                    st          <= S_FETCH;
                    instr_count <= instr_count + CNT_W'(1);
                end
                // Trapped until reset; counter stays frozen.
                S_ILLEGAL: st <= S_ILLEGAL;
                default:   st <= S_FETCH;
            endcase
        end
    end

    // Moore decode of the registered state. The FETCH load strobes wait for
    // the ack, and are held low while rst is asserted so reset is quiet.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        case (st)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ack & ~rst;
                pc_write  = mem_ack & ~rst;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_REX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            default: ;
        endcase
    end

    assign illegal = illegal_q;
    assign state   = st;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-cycle scoreboard of state, strobes and
// retire count for each instruction class, plus async reset and counter wrap.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b, alu_op;
        logic       reg_dst, reg_write, mem_to_reg, illegal;
    } ctl_t;

    typedef struct packed {
        logic [3:0]  st;
        ctl_t        ctl;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, mem_ack;
    logic [5:0]  opcode;
    ctl_t        ctl;
    logic [3:0]  state;
    logic [15:0] instr_count;

    logic        rst2, ack2;
    logic [5:0]  op2;
    logic        c2_mr, c2_mw, c2_iod, c2_irw, c2_pcw, c2_pcwc, c2_asa, c2_rd, c2_rw, c2_m2r, c2_ill;
    logic [1:0]  c2_pcs, c2_asb, c2_aop;
    logic [3:0]  c2_state;
    logic [1:0]  c2_cnt;

    int   n_cmp = 0, n_err = 0, n_step = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ack(mem_ack),
        .mem_read(ctl.mem_read), .mem_write(ctl.mem_write), .i_or_d(ctl.i_or_d),
        .ir_write(ctl.ir_write), .pc_write(ctl.pc_write), .pc_write_cond(ctl.pc_write_cond),
        .pc_source(ctl.pc_source), .alu_src_a(ctl.alu_src_a), .alu_src_b(ctl.alu_src_b),
        .alu_op(ctl.alu_op), .reg_dst(ctl.reg_dst), .reg_write(ctl.reg_write),
        .mem_to_reg(ctl.mem_to_reg), .illegal(ctl.illegal), .state(state),
        .instr_count(instr_count)
    );

    mips_multicycle_ctrl #(.CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst2), .opcode(op2), .mem_ack(ack2),
        .mem_read(c2_mr), .mem_write(c2_mw), .i_or_d(c2_iod), .ir_write(c2_irw),
        .pc_write(c2_pcw), .pc_write_cond(c2_pcwc), .pc_source(c2_pcs),
        .alu_src_a(c2_asa), .alu_src_b(c2_asb), .alu_op(c2_aop), .reg_dst(c2_rd),
        .reg_write(c2_rw), .mem_to_reg(c2_m2r), .illegal(c2_ill), .state(c2_state),
        .instr_count(c2_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference strobes for each state, written straight from the state table.
    function automatic ctl_t exp_ctl(input logic [3:0] s, input logic ack);
        ctl_t c = '0;
        case (s)
            4'd0: begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = ack; c.pc_write = ack; end
            4'd1: c.alu_src_b = 2'b11;
            4'd2: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            4'd3: begin c.mem_read = 1; c.i_or_d = 1; end
            4'd4: begin c.reg_write = 1; c.mem_to_reg = 1; end
            4'd5: begin c.mem_write = 1; c.i_or_d = 1; end
            4'd6: begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            4'd7: begin c.reg_write = 1; c.reg_dst = 1; end
            4'd8: begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
            4'd9: c.illegal = 1;
            default: ;
        endcase
        return c;
    endfunction

    // One clock of stimulus: drive, queue the expectation, compare at negedge.
    task automatic step(input logic ack, input logic [5:0] opc, input logic [3:0] est,
                        input logic [15:0] ecnt);
        exp_t e;
        mem_ack = ack;
        opcode  = opc;
        e.st = est; e.ctl = exp_ctl(est, ack); e.cnt = ecnt;
        sbq.push_back(e);
        @(negedge clk);
        e = sbq.pop_front();
        chk($sformatf("state@%0d", n_step), {28'd0, state}, {28'd0, e.st});
        chk($sformatf("ctl@%0d", n_step), {15'd0, ctl}, {15'd0, e.ctl});
        chk($sformatf("cnt@%0d", n_step), {16'd0, instr_count}, {16'd0, e.cnt});
        n_step++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; mem_ack = 0; opcode = 6'h00;
        rst2 = 1; ack2 = 1; op2 = 6'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", {28'd0, state}, 32'd0);
        chk("rst_ctl", {15'd0, ctl}, {15'd0, exp_ctl(4'd0, 1'b0)});
        chk("rst_cnt", {16'd0, instr_count}, 32'd0);
        @(posedge clk); #1;
        rst = 0;

        // R-type, zero-wait: 0,1,6,7,0
        step(1, 6'h00, 0, 0); step(1, 6'h00, 1, 0); step(1, 6'h3F, 6, 0);
        step(1, 6'h3F, 7, 0); step(1, 6'h23, 0, 1);

        // lw with three wait cycles in MEMRD; live opcode scrambled after DECODE
        step(1, 6'h23, 1, 1); step(1, 6'h3F, 2, 1);
        step(0, 6'h2B, 3, 1); step(0, 6'h2B, 3, 1); step(0, 6'h2B, 3, 1);
        step(1, 6'h2B, 3, 1); step(1, 6'h2B, 4, 1);

        // sw zero-wait; opcode switched to lw in MEMADR must not reroute it
        step(1, 6'h2B, 0, 2); step(1, 6'h2B, 1, 2); step(1, 6'h23, 2, 2);
        step(1, 6'h23, 5, 2);

        // beq after two FETCH wait cycles; opcode changed in BRANCH
        step(0, 6'h04, 0, 3); step(0, 6'h04, 0, 3); step(1, 6'h04, 0, 3);
        step(0, 6'h04, 1, 3); step(1, 6'h00, 8, 3); step(1, 6'h02, 0, 4);

        // unsupported opcode traps with a frozen count
        step(1, 6'h02, 1, 4);
        for (int i = 0; i < 20; i++)
            step(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 9, 4);

        rst = 1;
        @(negedge clk);
        chk("rst2_state", {28'd0, state}, 32'd0);
        chk("rst2_illegal", {31'd0, ctl.illegal}, 32'd0);
        chk("rst2_cnt", {16'd0, instr_count}, 32'd0);
        @(posedge clk); #1;
        rst = 0;

        // sw stalled in MEMWR, then reset lands between clock edges
        step(1, 6'h2B, 0, 0); step(1, 6'h2B, 1, 0); step(1, 6'h2B, 2, 0);
        step(0, 6'h2B, 5, 0); step(0, 6'h2B, 5, 0);
        @(negedge clk);
        #2 rst = 1;
        #1;
        chk("async_mem_write", {31'd0, ctl.mem_write}, 32'd0);
        chk("async_state", {28'd0, state}, 32'd0);
        @(posedge clk); #1;
        rst = 0;

        // 2-bit counter wraps after four back-to-back R-types
        @(posedge clk); #1;
        rst2 = 0;
        for (int k = 1; k <= 5; k++) begin
            exp_t e;
            e = '0; e.st = 4'd0; e.cnt = 16'(k % 4);
            sbq.push_back(e);
            repeat (4) @(posedge clk);
            @(negedge clk);
            e = sbq.pop_front();
            chk($sformatf("wrap_cnt%0d", k), {30'd0, c2_cnt}, {16'd0, e.cnt});
            chk($sformatf("wrap_state%0d", k), {28'd0, c2_state}, {28'd0, e.st});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
